// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles every non-clock/reset signal of the fetch PC unit.
//   master : the fetch PC unit itself (drives I-cache request, lane PCs,
//            instructions and lane valids; receives cache, predictor,
//            decode and execute-stage inputs)
//   slave  : the surrounding pipeline / I-cache / predictor environment
// Signal groups:
//   icache_req_*  : one outstanding group request (valid/ready/addr)
//   icache_rsp_*  : response for the outstanding request
//   if_pc_o/inst_o/if_valid_o : presented group to predictor
//   bp_*          : predictor per-lane next PC and taken indication
//   dec_*         : group hand-off to decode
//   ex_redirect_* : mispredict redirect from execute
// -----------------------------------------------------------------------------
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

interface fetch_pc_unit_if #(
  parameter int FETCH_WIDTH = `FETCH_WIDTH
);
  logic                         icache_req_valid_o;
  logic [31:0]                  icache_req_addr_o;
  logic                         icache_req_ready_i;
  logic                         icache_rsp_valid_i;
  logic [FETCH_WIDTH-1:0][31:0] icache_rsp_inst_i;
  logic [FETCH_WIDTH-1:0][31:0] if_pc_o;
  logic [FETCH_WIDTH-1:0][31:0] inst_o;
  logic [FETCH_WIDTH-1:0]       if_valid_o;
  logic [FETCH_WIDTH-1:0][31:0] bp_next_pc_i;
  logic                         bp_take_branch_i;
  logic [FETCH_WIDTH-1:0]       dec_valid_o;
  logic                         dec_ready_i;
  logic                         ex_redirect_i;
  logic [31:0]                  ex_redirect_pc_i;

  modport master (
    output icache_req_valid_o, icache_req_addr_o,
    input  icache_req_ready_i, icache_rsp_valid_i, icache_rsp_inst_i,
    output if_pc_o, inst_o, if_valid_o,
    input  bp_next_pc_i, bp_take_branch_i,
    output dec_valid_o,
    input  dec_ready_i, ex_redirect_i, ex_redirect_pc_i
  );

  modport slave (
    input  icache_req_valid_o, icache_req_addr_o,
    output icache_req_ready_i, icache_rsp_valid_i, icache_rsp_inst_i,
    input  if_pc_o, inst_o, if_valid_o,
    output bp_next_pc_i, bp_take_branch_i,
    input  dec_valid_o,
    output dec_ready_i, ex_redirect_i, ex_redirect_pc_i
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage front end ahead of the branch predictor. Owns the fetch PC,
// issues one FETCH_WIDTH-word I-cache request at a time, presents the
// returned group as lane PCs / instructions / valids, and selects the next
// fetch PC with priority: execute redirect > predictor target > sequential.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : fetch_pc_unit_if.master (cache, predictor, decode, redirect)
// -----------------------------------------------------------------------------
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

module fetch_pc_unit #(
  parameter int          FETCH_WIDTH = `FETCH_WIDTH,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  fetch_pc_unit_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [31:0]                  r_fetch_pc;
  logic [31:0]                  w_fetch_pc_nxt;
  logic                         r_squash;
  logic                         w_squash_nxt;
  logic [FETCH_WIDTH-1:0][31:0] r_inst;
  logic                         w_load_group;

  logic [FETCH_WIDTH-1:0][31:0] w_lane_pc;
  logic [FETCH_WIDTH-1:0]       w_keep;
  logic                         w_found;
  logic [31:0]                  w_target;
  logic                         w_taken;
  logic [FETCH_WIDTH-1:0]       w_if_valid;

  // Lane PCs and taken-lane search. A lane is "taken" when its predicted
  // next PC differs from its fall-through; w_keep marks lanes up to and
  // including the first such lane, which is exactly the decode mask.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_lane_pc = '0;
    w_keep    = '0;
    w_found   = 1'b0;
    w_target  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_lane_pc[i] = r_fetch_pc + 32'(4 * i);
      w_keep[i]    = ~w_found;
      if (!w_found && (bus.bp_next_pc_i[i] != w_lane_pc[i] + 32'd4)) begin
        w_found  = 1'b1;
        w_target = bus.bp_next_pc_i[i];
      end
    end
  end

  assign w_taken    = bus.bp_take_branch_i & w_found;
  assign w_if_valid = (r_state == PRESENT) ? '1 : '0;

  // Next-state / next-PC logic. Redirect dominates in every state but IDLE.
  // squash marks an accepted request whose response must be discarded.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_squash_nxt   = r_squash;
    w_load_group   = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (bus.ex_redirect_i) begin
          w_fetch_pc_nxt = bus.ex_redirect_pc_i;
          if (bus.icache_req_ready_i) begin
            w_squash_nxt = 1'b1;
            w_state_nxt  = WAIT;
          end
        end else if (bus.icache_req_ready_i) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.ex_redirect_i) begin
          w_fetch_pc_nxt = bus.ex_redirect_pc_i;
          if (bus.icache_rsp_valid_i) begin
            w_squash_nxt = 1'b0;
            w_state_nxt  = REQ;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end else if (bus.icache_rsp_valid_i) begin
          if (r_squash) begin
            w_squash_nxt = 1'b0;
            w_state_nxt  = REQ;
          end else begin
            w_load_group = 1'b1;
            w_state_nxt  = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (bus.ex_redirect_i) begin
          w_fetch_pc_nxt = bus.ex_redirect_pc_i;
          w_state_nxt    = REQ;
        end else if (bus.dec_ready_i) begin
          w_fetch_pc_nxt = w_taken ? w_target
                                   : r_fetch_pc + 32'(4 * FETCH_WIDTH);
          w_state_nxt    = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_squash   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_squash   <= w_squash_nxt;
    end
  end

  // NOTE: the group register is only FETCH_WIDTH words, so it is reset to
  // give inst_o a defined value; a deep storage array would not be.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inst <= '0;
    end else if (w_load_group) begin
      r_inst <= bus.icache_rsp_inst_i;
    end
  end

  assign bus.icache_req_valid_o = (r_state == REQ);
  assign bus.icache_req_addr_o  = r_fetch_pc;
  assign bus.if_pc_o            = w_lane_pc;
  assign bus.inst_o             = r_inst;
  assign bus.if_valid_o         = w_if_valid;
  // A redirect kills the presented group in the same cycle.
  assign bus.dec_valid_o        = w_if_valid
                                & (w_taken ? w_keep : '1)
                                & {FETCH_WIDTH{~bus.ex_redirect_i}};

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit with FETCH_WIDTH=2, RESET_PC=0.
// Expected request addresses are pushed to a scoreboard queue when the
// stimulus that determines them is driven, and popped when the DUT raises
// a request. A table of predictor scenarios is followed by hand-written
// stall, redirect, wrap and reset sequences.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;
  localparam int FW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_pc_unit_if #(.FETCH_WIDTH(FW)) bus ();

  fetch_pc_unit #(.FETCH_WIDTH(FW), .RESET_PC(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        take;
    logic [31:0] nxt0;
    logic [31:0] nxt1;
    logic [1:0]  exp_dec;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a request, then compare its address with the
  // oldest scoreboard entry.
  task automatic wait_req(output logic [31:0] base);
    int n = 0;
    while (!bus.icache_req_valid_o && n < 20) begin
      step();
      n++;
    end
    check("req_valid", bus.icache_req_valid_o, 1'b1);
    base = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    check("req_addr", bus.icache_req_addr_o, base);
  endtask

  // Accept a request, return a group, and check the PRESENT outputs.
  task automatic fetch_group(input logic [31:0] i0, input logic [31:0] i1,
                             output logic [31:0] base);
    wait_req(base);
    bus.icache_req_ready_i = 1'b1;
    step();
    bus.icache_req_ready_i = 1'b0;
    check("wait_if_valid", bus.if_valid_o, 2'b00);
    check("wait_req_valid", bus.icache_req_valid_o, 1'b0);
    bus.icache_rsp_valid_i = 1'b1;
    bus.icache_rsp_inst_i  = {i1, i0};
    step();
    bus.icache_rsp_valid_i = 1'b0;
    bus.icache_rsp_inst_i  = '0;
    check("present_if_valid", bus.if_valid_o, 2'b11);
    check("present_if_pc", bus.if_pc_o, {base + 32'd4, base});
    check("present_inst", bus.inst_o, {i1, i0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;

    //           inst0         inst1         take  nxt0          nxt1          dec    next
    vecs[0] = '{32'h1000_0000, 32'h1000_0001, 1'b0, 32'h0000_0008, 32'h0000_0004, 2'b11, 32'h0000_0008};
    vecs[1] = '{32'h2000_0000, 32'h2000_0001, 1'b0, 32'h0000_0010, 32'h0000_000C, 2'b11, 32'h0000_0010};
    vecs[2] = '{32'h3000_0000, 32'h3000_0001, 1'b1, 32'h0000_0014, 32'h0000_0080, 2'b11, 32'h0000_0080};
    vecs[3] = '{32'h4000_0000, 32'h4000_0001, 1'b1, 32'h0000_0040, 32'h0000_0088, 2'b01, 32'h0000_0040};
    vecs[4] = '{32'h5000_0000, 32'h5000_0001, 1'b1, 32'h0000_0044, 32'h0000_0048, 2'b11, 32'h0000_0048};
    vecs[5] = '{32'h6000_0000, 32'h6000_0001, 1'b0, 32'h0000_0300, 32'h0000_0050, 2'b11, 32'h0000_0050};
    vecs[6] = '{32'h7000_0000, 32'h7000_0001, 1'b1, 32'h0000_0010, 32'h0000_0999, 2'b01, 32'h0000_0010};

    reset                  = 1'b1;
    bus.icache_req_ready_i = 1'b0;
    bus.icache_rsp_valid_i = 1'b0;
    bus.icache_rsp_inst_i  = '0;
    bus.bp_next_pc_i       = '0;
    bus.bp_take_branch_i   = 1'b0;
    bus.dec_ready_i        = 1'b0;
    bus.ex_redirect_i      = 1'b0;
    bus.ex_redirect_pc_i   = '0;
    #1;
    check("rst_req_valid", bus.icache_req_valid_o, 1'b0);
    check("rst_req_addr", bus.icache_req_addr_o, 32'h0);
    check("rst_if_valid", bus.if_valid_o, 2'b00);
    check("rst_dec_valid", bus.dec_valid_o, 2'b00);
    check("rst_inst", bus.inst_o, 64'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("idle_req_valid", bus.icache_req_valid_o, 1'b0);
    sb_q.push_back(32'h0);
    step();
    check("first_req_latency", bus.icache_req_valid_o, 1'b1);

    // Table-driven predictor scenarios.
    for (int i = 0; i < 7; i++) begin
      fetch_group(vecs[i].inst0, vecs[i].inst1, base);
      bus.bp_take_branch_i = vecs[i].take;
      bus.bp_next_pc_i     = {vecs[i].nxt1, vecs[i].nxt0};
      #1;
      check($sformatf("vec%0d_dec_valid", i), bus.dec_valid_o, vecs[i].exp_dec);
      bus.dec_ready_i = 1'b1;
      sb_q.push_back(vecs[i].exp_next);
      step();
      bus.dec_ready_i      = 1'b0;
      bus.bp_take_branch_i = 1'b0;
    end

    // Decode stall: outputs held, no new request for 3 cycles.
    fetch_group(32'hA000_0000, 32'hA000_0001, base);
    bus.bp_next_pc_i = {base + 32'd8, base + 32'd4};
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_req_valid", bus.icache_req_valid_o, 1'b0);
      check("stall_if_pc", bus.if_pc_o, {base + 32'd4, base});
      check("stall_dec_valid", bus.dec_valid_o, 2'b11);
      check("stall_inst", bus.inst_o, {32'hA000_0001, 32'hA000_0000});
    end
    bus.dec_ready_i = 1'b1;
    sb_q.push_back(base + 32'd8);
    step();
    bus.dec_ready_i = 1'b0;
    check("stall_release_req", bus.icache_req_valid_o, 1'b1);

    // Redirect in WAIT, response two cycles later is dropped.
    wait_req(base);
    bus.icache_req_ready_i = 1'b1;
    step();
    bus.icache_req_ready_i = 1'b0;
    bus.ex_redirect_i      = 1'b1;
    bus.ex_redirect_pc_i   = 32'h0000_0200;
    #1;
    check("wait_redir_dec_valid", bus.dec_valid_o, 2'b00);
    sb_q.push_back(32'h0000_0200);
    step();
    bus.ex_redirect_i = 1'b0;
    check("squash_if_valid", bus.if_valid_o, 2'b00);
    step();
    check("squash_req_valid", bus.icache_req_valid_o, 1'b0);
    bus.icache_rsp_valid_i = 1'b1;
    bus.icache_rsp_inst_i  = {32'hBAD0_0001, 32'hBAD0_0000};
    #1;
    check("squash_rsp_dec_valid", bus.dec_valid_o, 2'b00);
    step();
    bus.icache_rsp_valid_i = 1'b0;
    check("dropped_if_valid", bus.if_valid_o, 2'b00);
    check("dropped_dec_valid", bus.dec_valid_o, 2'b00);
    wait_req(base);

    // Redirect in REQ without ready, then a sequential step that wraps.
    bus.ex_redirect_i    = 1'b1;
    bus.ex_redirect_pc_i = 32'hFFFF_FFF8;
    step();
    bus.ex_redirect_i = 1'b0;
    sb_q.push_back(32'hFFFF_FFF8);
    fetch_group(32'hC000_0000, 32'hC000_0001, base);
    bus.bp_next_pc_i = {32'h0, 32'hFFFF_FFFC};
    #1;
    check("wrap_dec_valid", bus.dec_valid_o, 2'b11);
    bus.dec_ready_i = 1'b1;
    sb_q.push_back(32'h0);
    step();
    bus.dec_ready_i = 1'b0;

    // Redirect together with dec_ready in PRESENT: redirect wins.
    fetch_group(32'hD000_0000, 32'hD000_0001, base);
    bus.bp_take_branch_i = 1'b1;
    bus.bp_next_pc_i     = {32'h0000_0008, 32'h0000_0040};
    bus.dec_ready_i      = 1'b1;
    bus.ex_redirect_i    = 1'b1;
    bus.ex_redirect_pc_i = 32'h0000_0300;
    #1;
    check("present_redir_dec_valid", bus.dec_valid_o, 2'b00);
    sb_q.push_back(32'h0000_0300);
    step();
    bus.dec_ready_i      = 1'b0;
    bus.ex_redirect_i    = 1'b0;
    bus.bp_take_branch_i = 1'b0;
    wait_req(base);

    // Reset while WAITing for a response.
    bus.icache_req_ready_i = 1'b1;
    step();
    bus.icache_req_ready_i = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_req_valid", bus.icache_req_valid_o, 1'b0);
    check("midrst_req_addr", bus.icache_req_addr_o, 32'h0);
    check("midrst_if_valid", bus.if_valid_o, 2'b00);
    check("midrst_dec_valid", bus.dec_valid_o, 2'b00);
    step();
    step();
    reset = 1'b0;
    #1;
    check("midrst_idle_req_valid", bus.icache_req_valid_o, 1'b0);
    sb_q.delete();
    sb_q.push_back(32'h0);
    step();
    check("midrst_req_latency", bus.icache_req_valid_o, 1'b1);
    fetch_group(32'hE000_0000, 32'hE000_0001, base);
    bus.bp_next_pc_i = {32'h8, 32'h4};
    #1;
    check("midrst_dec_valid_after", bus.dec_valid_o, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
